// File: rtl/ucie_lane_striper.sv
// ucie_lane_striper: splits RDI flits into per-channel chunks over the enabled SDR lanes,
// stretching a flit over several beats when lanes are degraded.
module ucie_lane_striper #(
  parameter int DATA_W = 384,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   lp_data,
  input  logic                lp_valid,
  input  logic                lp_irdy,
  output logic                pl_trdy,
  input  logic [NUM_CH-1:0]   i_ch_mask,
  input  logic                i_phy_rdy,
  output logic [DATA_W-1:0]   o_ch_data,
  output logic [NUM_CH-1:0]   o_ch_vld,
  output logic                o_last,
  output logic [CNT_W-1:0]    o_flit_cnt,
  output logic                o_mask_err,
  input  logic                i_err_clr
);
  localparam int CH_W = DATA_W / NUM_CH;
  localparam int BW   = $clog2(NUM_CH) + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_data, r_ch_data, w_src_data, w_map_data;
  logic [NUM_CH-1:0]   r_mask, r_ch_vld, w_src_mask, w_map_vld;
  logic [BW-1:0]       r_beat, w_src_beat;
  logic [CNT_W-1:0]    r_flit_cnt;
  logic                r_last, r_mask_err, w_map_last;
  logic                w_any, w_slot, w_accept, w_advance, w_done, w_err_set;
  assign w_any     = |i_ch_mask;
  // a new flit may enter when idle, or in the cycle the last beat is consumed
  assign w_slot    = (r_state == IDLE) | (r_last & i_phy_rdy);
  assign pl_trdy   = rst_n & w_slot & w_any;
  assign w_accept  = lp_valid & lp_irdy & pl_trdy;
  assign w_advance = (r_state == SEND) & i_phy_rdy;
  assign w_done    = w_advance & r_last;
  assign w_err_set = lp_valid & lp_irdy & w_slot & ~w_any;
  assign o_ch_data  = r_ch_data;
  assign o_ch_vld   = r_ch_vld;
  assign o_last     = r_last;
  assign o_flit_cnt = r_flit_cnt;
  assign o_mask_err = r_mask_err;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE)
      w_state_nxt = w_accept ? SEND : IDLE;
    else if (w_done)
      w_state_nxt = w_accept ? SEND : IDLE;
  end
  // beat being loaded next: beat 0 of a new flit, or the following beat of the current one
  always_comb begin
    int k;
    int r;
    w_src_data = w_accept ? lp_data : r_data;
    w_src_mask = w_accept ? i_ch_mask : r_mask;
    w_src_beat = w_accept ? '0 : r_beat + BW'(1);
    w_map_data = '0;
    w_map_vld  = '0;
    k = 0;
    r = 0;
    for (int n = 0; n < NUM_CH; n++)
      k = k + int'(w_src_mask[n]);
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_src_mask[n]) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (c == int'(w_src_beat) * k + r) begin
            w_map_data[n*CH_W +: CH_W] = w_src_data[c*CH_W +: CH_W];
            w_map_vld[n] = 1'b1;
          end
        end
        r = r + 1;
      end
    end
    w_map_last = (int'(w_src_beat) + 1) * k >= NUM_CH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_mask     <= '0;
      r_beat     <= '0;
      r_ch_data  <= '0;
      r_ch_vld   <= '0;
      r_last     <= 1'b0;
      r_flit_cnt <= '0;
      r_mask_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask_err <= i_err_clr ? 1'b0 : (r_mask_err | w_err_set);
      if (w_done)
        r_flit_cnt <= r_flit_cnt + CNT_W'(1);
      if (w_accept) begin
        r_data    <= lp_data;
        r_mask    <= i_ch_mask;
        r_beat    <= '0;
        r_ch_data <= w_map_data;
        r_ch_vld  <= w_map_vld;
        r_last    <= w_map_last;
      end else if (w_advance & ~r_last) begin
        r_beat    <= w_src_beat;
        r_ch_data <= w_map_data;
        r_ch_vld  <= w_map_vld;
        r_last    <= w_map_last;
      end else if (w_done) begin
        r_ch_vld  <= '0;
        r_last    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ucie_lane_striper.sv
// tb_ucie_lane_striper: directed checks of a 2-channel and a 4-channel striper.
module tb_ucie_lane_striper;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [383:0] d2 = '0;
  logic         v2 = 1'b0, irdy2 = 1'b1, phy2 = 1'b1, clr2 = 1'b0;
  logic [1:0]   m2 = 2'b11;
  logic         trdy2, last2, err2;
  logic [383:0] od2;
  logic [1:0]   ov2;
  logic [15:0]  cnt2;
  logic [31:0]  d4 = '0;
  logic         v4 = 1'b0, irdy4 = 1'b1, phy4 = 1'b1, clr4 = 1'b0;
  logic [3:0]   m4 = 4'b1111;
  logic         trdy4, last4, err4;
  logic [31:0]  od4;
  logic [3:0]   ov4;
  logic [15:0]  cnt4;
  logic [191:0] ca, cb;
  int n_checks = 0, n_errs = 0;
  always #5 clk = ~clk;
  ucie_lane_striper #(.DATA_W(384), .NUM_CH(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .lp_data(d2), .lp_valid(v2), .lp_irdy(irdy2), .pl_trdy(trdy2),
    .i_ch_mask(m2), .i_phy_rdy(phy2), .o_ch_data(od2), .o_ch_vld(ov2), .o_last(last2),
    .o_flit_cnt(cnt2), .o_mask_err(err2), .i_err_clr(clr2));
  ucie_lane_striper #(.DATA_W(32), .NUM_CH(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .lp_data(d4), .lp_valid(v4), .lp_irdy(irdy4), .pl_trdy(trdy4),
    .i_ch_mask(m4), .i_phy_rdy(phy4), .o_ch_data(od4), .o_ch_vld(ov4), .o_last(last4),
    .o_flit_cnt(cnt4), .o_mask_err(err4), .i_err_clr(clr4));
  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic beat2(input string tag, input logic [383:0] data, input logic [1:0] vld, input logic last);
    chk({tag, "_data"}, od2, data);
    chk({tag, "_vld"}, ov2, vld);
    chk({tag, "_last"}, last2, last);
  endtask
  task automatic beat4(input string tag, input logic [31:0] data, input logic [3:0] vld, input logic last);
    chk({tag, "_data"}, od4, data);
    chk({tag, "_vld"}, ov4, vld);
    chk({tag, "_last"}, last4, last);
  endtask
  initial begin
    tick();
    chk("rst_trdy", trdy2, 1'b0);
    beat2("rst", '0, 2'b00, 1'b0);
    chk("rst_cnt", cnt2, 16'd0);
    chk("rst_err", err2, 1'b0);
    rst_n = 1'b1;
    #1 chk("rel_trdy", trdy2, 1'b1);
    // T1: full mask, one beat
    ca = 192'hA; cb = 192'hB;
    d2 = {cb, ca}; v2 = 1'b1;
    tick(); v2 = 1'b0;
    beat2("t1", {cb, ca}, 2'b11, 1'b1);
    tick();
    chk("t1_cnt", cnt2, 16'd1);
    chk("t1_idle_vld", ov2, 2'b00);
    chk("t1_hold_data", od2, {cb, ca});
    // T2: only ch1, two beats, back-to-back second flit
    m2 = 2'b10; d2 = {192'hD, 192'hC}; v2 = 1'b1;
    #1 chk("t2_trdy0", trdy2, 1'b1);
    tick(); d2 = {192'hF, 192'hE};
    #1 chk("t2_trdy_beat0", trdy2, 1'b0);
    beat2("t2_b0", {192'hC, 192'h0}, 2'b10, 1'b0);
    tick();
    beat2("t2_b1", {192'hD, 192'h0}, 2'b10, 1'b1);
    chk("t2_trdy_beat1", trdy2, 1'b1);
    tick(); v2 = 1'b0;
    beat2("t2_f2b0", {192'hE, 192'h0}, 2'b10, 1'b0);
    tick();
    beat2("t2_f2b1", {192'hF, 192'h0}, 2'b10, 1'b1);
    tick();
    chk("t2_cnt", cnt2, 16'd3);
    chk("t2_idle_vld", ov2, 2'b00);
    // T3: 4 channels, mask 1011
    m4 = 4'b1011; d4 = 32'h44332211; v4 = 1'b1;
    #1 chk("t3_trdy", trdy4, 1'b1);
    tick(); v4 = 1'b0;
    beat4("t3_b0", 32'h33002211, 4'b1011, 1'b0);
    tick();
    beat4("t3_b1", 32'h00000044, 4'b0001, 1'b1);
    tick();
    chk("t3_cnt", cnt4, 16'd1);
    chk("t3_idle_vld", ov4, 4'b0000);
    m4 = 4'b0110; d4 = 32'hDDCCBBAA; v4 = 1'b1;
    tick(); v4 = 1'b0;
    beat4("t3m_b0", 32'h00BBAA00, 4'b0110, 1'b0);
    tick();
    beat4("t3m_b1", 32'h00DDCC00, 4'b0110, 1'b1);
    tick();
    chk("t3m_cnt", cnt4, 16'd2);
    // T4: stall 5 cycles mid-flit
    d2 = {192'h2222, 192'h1111}; v2 = 1'b1;
    tick(); v2 = 1'b0; phy2 = 1'b0;
    beat2("t4_b0", {192'h1111, 192'h0}, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      beat2("t4_stall", {192'h1111, 192'h0}, 2'b10, 1'b0);
    end
    phy2 = 1'b1;
    tick();
    beat2("t4_b1", {192'h2222, 192'h0}, 2'b10, 1'b1);
    tick();
    chk("t4_cnt", cnt2, 16'd4);
    m2 = 2'b11; d2 = {192'd100, 192'd0}; v2 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      beat2("t4_b2b", {192'(100 + j), 192'(j)}, 2'b11, 1'b1);
      if (j < 7) d2 = {192'(101 + j), 192'(j + 1)};
      else v2 = 1'b0;
      #1 chk("t4_b2b_trdy", trdy2, 1'b1);
    end
    tick();
    chk("t4_b2b_cnt", cnt2, 16'd12);
    chk("t4_b2b_idle", ov2, 2'b00);
    // T5: mask error, clear, then mid-flit mask change
    m2 = 2'b00; v2 = 1'b1;
    #1 chk("t5_trdy_mask0", trdy2, 1'b0);
    tick();
    chk("t5_err_set", err2, 1'b1);
    chk("t5_no_beat", ov2, 2'b00);
    clr2 = 1'b1;
    tick();
    chk("t5_err_clr", err2, 1'b0);
    clr2 = 1'b0; m2 = 2'b01; d2 = {192'h4444, 192'h3333};
    #1 chk("t5_trdy_mask1", trdy2, 1'b1);
    tick(); v2 = 1'b0; m2 = 2'b11;
    beat2("t5_b0", {192'h0, 192'h3333}, 2'b01, 1'b0);
    tick();
    beat2("t5_b1", {192'h0, 192'h4444}, 2'b01, 1'b1);
    tick();
    chk("t5_cnt", cnt2, 16'd13);
    chk("t5_err_stays", err2, 1'b0);
    // T6: asynchronous reset during beat 0
    m2 = 2'b10; d2 = {192'h6666, 192'h5555}; v2 = 1'b1;
    tick(); v2 = 1'b0;
    beat2("t6_b0", {192'h5555, 192'h0}, 2'b10, 1'b0);
    #2 rst_n = 1'b0;
    #1 beat2("t6_rst", '0, 2'b00, 1'b0);
    chk("t6_rst_cnt", cnt2, 16'd0);
    chk("t6_rst_trdy", trdy2, 1'b0);
    tick(); m2 = 2'b11; rst_n = 1'b1;
    #1 chk("t6_rel_trdy", trdy2, 1'b1);
    tick();
    beat2("t6_no_stale", '0, 2'b00, 1'b0);
    tick();
    chk("t6_no_stale2", ov2, 2'b00);
    chk("t6_cnt", cnt2, 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
